// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        bit_end   = (timer_q == TW'(PRESCALE - 1));

        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    timer_d   = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line value is registered from the state being entered, so it changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed scoreboard bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int DW = 8;
    localparam int PS = 8;

    logic          clk = 1'b0;
    logic          ARSTn;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    uart_tx_serializer #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .clk       (clk),
        .ARSTn     (ARSTn),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line value for every cycle of a frame, start to stop.
    task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        logic pbit;
        pbit = 1'b0;
        for (int k = 0; k < DW; k++) pbit = pbit ^ d[k];
        pbit = pbit ^ ptyp;
        repeat (PS) exp_q.push_back(1'b0);
        for (int k = 0; k < DW; k++) repeat (PS) exp_q.push_back(d[k]);
        if (pen) repeat (PS) exp_q.push_back(pbit);
        repeat (PS) exp_q.push_back(1'b1);
    endtask

    task automatic check_cycles(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                b = 1'b1;
            end else begin
                b = exp_q.pop_front();
            end
            chk("tx_bit", TX_OUT, b);
            chk("busy_in_frame", busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"}, TX_OUT, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        push_frame(d, pen, ptyp);
        @(negedge clk);
        DATA_VALID = 1'b0;
        check_cycles(pen ? (DW + 3) * PS : (DW + 2) * PS);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        check_idle("post_frame");
    endtask

    initial begin
        ARSTn      = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        ARSTn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_idle("idle20");
        end

        send(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        send(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        send(8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        send(8'h00, 1'b1, 1'b1);
        @(negedge clk);

        // DATA_VALID pulsed mid-frame with other data must be ignored.
        fork
            begin
                repeat (30) @(negedge clk);
                P_DATA     = 8'h12;
                DATA_VALID = 1'b1;
                @(negedge clk);
                DATA_VALID = 1'b0;
            end
        join_none
        send(8'hFF, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_idle("ignored_dv");
        end

        // Held DATA_VALID: first frame keeps 0xA5, one idle cycle, then 0x3C.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0);
        fork
            begin
                repeat (5) @(negedge clk);
                P_DATA = 8'h3C;
            end
        join_none
        @(negedge clk);
        check_cycles((DW + 2) * PS);
        check_idle("b2b_gap");
        push_frame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        DATA_VALID = 1'b0;
        check_cycles((DW + 2) * PS);
        check_idle("b2b_end");
        @(negedge clk);

        // Asynchronous reset during data bit 4 (a zero bit of 0xA5).
        P_DATA     = 8'hA5;
        DATA_VALID = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        DATA_VALID = 1'b0;
        check_cycles(5 * PS + 2);
        chk("pre_reset_tx", TX_OUT, 1'b0);
        #2 ARSTn = 1'b0;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        @(negedge clk);
        ARSTn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_idle("after_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
